// File: rtl/ram8_pkg.sv
// Shared sizes and FSM state encoding for the ram8 burst initiator.
// Imported by ram8_burst_ctr and ram8_initiator.
package ram8_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  typedef enum logic [2:0] {
    S_CLEAR    = 3'd0,
    S_IDLE     = 3'd1,
    S_WRITE    = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_CAP   = 3'd4,
    S_RD_RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/ram8_burst_ctr.sv
// Burst address/beat counter: load start+len, step wraps mod DEPTH.
// Ports: clk, rst_n, load, start, len, step -> addr, last.
module ram8_burst_ctr
  import ram8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start,
  input  logic [ADDR_W-1:0] len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] cnt;

  // DEPTH is a power of two, so natural overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= start;
      cnt  <= len;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      if (cnt != '0)
        cnt <= cnt - ADDR_W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/ram8_initiator.sv
// Burst initiator driving an 8x8 RAM from a cmd / wdata / rdata stream.
// Ports: cmd_*, w*, r*, ram_* ; macro RAM8_INIT_CLEAR_EN adds CLEAR.
module ram8_initiator
  import ram8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              rlast,
  output logic              ram_wr_enb,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_rd_enb,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_dataout
);

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              accept;
  logic              wr_beat;
  logic              rd_hs;
  logic              clr_beat;
  logic              step;

  assign accept  = cmd_valid && cmd_ready;
  assign wr_beat = (state == S_WRITE) && wvalid;
  assign rd_hs   = (state == S_RD_RESP) && rready;
`ifdef RAM8_INIT_CLEAR_EN
  assign clr_beat = (state == S_CLEAR);
`else
  assign clr_beat = 1'b0;
`endif
  assign step = wr_beat | (rd_hs & ~last) | clr_beat;

  ram8_burst_ctr u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .start (cmd_addr),
    .len   (cmd_len),
    .step  (step),
    .addr  (addr),
    .last  (last)
  );

  always_comb begin
    nxt = state;
    unique case (state)
`ifdef RAM8_INIT_CLEAR_EN
      S_CLEAR:
        if (addr == ADDR_W'(DEPTH - 1))
          nxt = S_IDLE;
`endif
      S_IDLE:
        if (accept)
          nxt = cmd_wr ? S_WRITE : S_RD_ISSUE;
      S_WRITE:
        if (wvalid && last)
          nxt = S_IDLE;
      S_RD_ISSUE:
        nxt = S_RD_CAP;
      S_RD_CAP:
        nxt = S_RD_RESP;
      S_RD_RESP:
        if (rready)
          nxt = last ? S_IDLE : S_RD_ISSUE;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RAM8_INIT_CLEAR_EN
      state <= S_CLEAR;
`else
      state <= S_IDLE;
`endif
      rdata <= '0;
    end else begin
      state <= nxt;
      if (state == S_RD_CAP)
        rdata <= ram_dataout;
    end
  end

  // Every strobe is qualified by rst_n so nothing leaks while in reset.
  always_comb begin
    cmd_ready   = rst_n && (state == S_IDLE);
    wready      = rst_n && (state == S_WRITE);
    rvalid      = rst_n && (state == S_RD_RESP);
    rlast       = rst_n && (state == S_RD_RESP) && last;
    ram_wr_enb  = rst_n && (wr_beat || clr_beat);
    ram_rd_enb  = rst_n && (state == S_RD_ISSUE);
    ram_wr_addr = addr;
    ram_rd_addr = addr;
    ram_din     = '0;
    if (state == S_WRITE)
      ram_din = wdata;
  end

endmodule

// File: tb/tb_ram8_initiator.sv
// Directed self-checking bench for ram8_initiator with a RAM model.
// Checks write/read bursts, wrap, stalls, backpressure and reset.
module tb_ram8_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [2:0] cmd_addr;
  logic [2:0] cmd_len;
  logic       wvalid;
  logic       wready;
  logic [7:0] wdata;
  logic       rvalid;
  logic       rready;
  logic [7:0] rdata;
  logic       rlast;
  logic       ram_wr_enb;
  logic [2:0] ram_wr_addr;
  logic [7:0] ram_din;
  logic       ram_rd_enb;
  logic [2:0] ram_rd_addr;
  logic [7:0] ram_dataout;

  always #5 clk = ~clk;

  ram8_initiator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rlast       (rlast),
    .ram_wr_enb  (ram_wr_enb),
    .ram_wr_addr (ram_wr_addr),
    .ram_din     (ram_din),
    .ram_rd_enb  (ram_rd_enb),
    .ram_rd_addr (ram_rd_addr),
    .ram_dataout (ram_dataout)
  );

  logic [7:0] mem [8];

  always @(posedge clk) begin
    if (ram_wr_enb)
      mem[ram_wr_addr] <= ram_din;
    if (ram_rd_enb)
      ram_dataout <= mem[ram_rd_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [2:0] wa_q [$];
  logic [7:0] wd_q [$];
  logic [2:0] ra_q [$];
  logic [7:0] bd_q [$];
  logic       bl_q [$];
  int         bc_q [$];
  logic [7:0] ex   [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so negedge sees the values the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n === 1'b1)
      chk("wr_rd_excl", 32'(ram_wr_enb & ram_rd_enb), 32'd0);
    if (ram_wr_enb) begin
      wa_q.push_back(ram_wr_addr);
      wd_q.push_back(ram_din);
    end
    if (ram_rd_enb)
      ra_q.push_back(ram_rd_addr);
    if (rvalid && rready) begin
      bd_q.push_back(rdata);
      bl_q.push_back(rlast);
      bc_q.push_back(cyc);
    end
  end

  task automatic clr_logs();
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    bd_q.delete(); bl_q.delete(); bc_q.delete();
  endtask

  task automatic send(input logic wr, input logic [2:0] a,
                      input logic [2:0] l);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [2:0] l,
                          input logic [7:0] base, input int stall_at,
                          input string tag);
    clr_logs();
    send(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (i == stall_at) begin
        wvalid = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk({tag, "_stall_enb"}, 32'(ram_wr_enb), 32'd0);
          chk({tag, "_stall_busy"}, 32'(cmd_ready), 32'd0);
          @(posedge clk); #1;
        end
      end
      wvalid = 1'b1;
      wdata  = base + 8'(i);
      @(negedge clk);
      chk({tag, "_wready"}, 32'(wready), 32'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_wready_off"}, 32'(wready), 32'd0);
    chk({tag, "_nbeats"}, wa_q.size(), 32'(l) + 1);
    for (int i = 0; i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(wa_q[i]), 32'(3'(a + 3'(i))));
      chk({tag, "_data"}, 32'(wd_q[i]), 32'(base + 8'(i)));
    end
  endtask

  task automatic do_read(input logic [2:0] a, input logic [2:0] l,
                         input int hold, input string tag);
    int k;
    rready = (hold == 0);
    clr_logs();
    send(1'b0, a, l);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      k = i;
      if (rvalid) break;
    end
    chk({tag, "_latency"}, k, 3);
    if (hold > 0) begin
      repeat (hold) begin
        chk({tag, "_bp_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_bp_rdata"}, 32'(rdata), 32'(ex[0]));
        chk({tag, "_bp_rd_enb"}, 32'(ram_rd_enb), 32'd0);
        @(negedge clk);
      end
      chk({tag, "_bp_strobes"}, ra_q.size(), 1);
      @(posedge clk); #1;
      rready = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk({tag, "_done"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_nbeats"}, bd_q.size(), 32'(l) + 1);
    chk({tag, "_nstrobes"}, ra_q.size(), 32'(l) + 1);
    for (int i = 0; i < bd_q.size(); i++) begin
      chk({tag, "_rdata"}, 32'(bd_q[i]), 32'(ex[i]));
      chk({tag, "_rlast"}, 32'(bl_q[i]), 32'(i == int'(l)));
      if (i > 0 && hold == 0)
        chk({tag, "_spacing"}, bc_q[i] - bc_q[i-1], 3);
    end
    for (int i = 0; i < ra_q.size(); i++)
      chk({tag, "_rd_addr"}, 32'(ra_q[i]), 32'(3'(a + 3'(i))));
  endtask

  task automatic wait_clear(input string tag);
`ifdef RAM8_INIT_CLEAR_EN
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_nclr"}, wa_q.size(), 8);
    for (int i = 0; i < wa_q.size(); i++) begin
      chk({tag, "_clr_addr"}, 32'(wa_q[i]), i);
      chk({tag, "_clr_data"}, 32'(wd_q[i]), 0);
    end
`else
    @(negedge clk);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_no_wr"}, wa_q.size(), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nr;
    int nw;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 3'd5;
    cmd_len   = 3'd2;
    wvalid    = 1'b1;
    wdata     = 8'h55;
    rready    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_wr_enb", 32'(ram_wr_enb), 32'd0);
    chk("rst_rd_enb", 32'(ram_rd_enb), 32'd0);
    chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    @(posedge clk); #1;
    clr_logs();
    cmd_valid = 1'b0;
    wvalid    = 1'b0;
    rst_n     = 1'b1;
    wait_clear("boot");

    @(posedge clk); #1;
    do_write(3'd2, 3'd3, 8'hA1, -1, "wr");
    ex = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h0, 8'h0, 8'h0, 8'h0};
    @(posedge clk); #1;
    do_read(3'd2, 3'd3, 0, "rd");

    @(posedge clk); #1;
    do_write(3'd6, 3'd3, 8'hB1, 2, "wrap");
    ex = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h0, 8'h0, 8'h0, 8'h0};
    @(posedge clk); #1;
    do_read(3'd6, 3'd3, 10, "bp");

    @(posedge clk); #1;
    rready = 1'b1;
    clr_logs();
    send(1'b0, 3'd2, 3'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid) break;
    end
    chk("mid_rvalid_seen", 32'(rvalid), 32'd1);
    chk("mid_rdata_seen", 32'(rdata), 32'hA1);
    rst_n = 1'b0;
    #1;
    chk("mid_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rdata", 32'(rdata), 32'd0);
    chk("mid_rlast", 32'(rlast), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rd_enb", 32'(ram_rd_enb), 32'd0);
    nr = ra_q.size();
    nw = wa_q.size();
    repeat (3) begin
      @(negedge clk);
      chk("mid_hold_rd", 32'(ram_rd_enb), 32'd0);
      chk("mid_hold_wr", 32'(ram_wr_enb), 32'd0);
      chk("mid_hold_rdy", 32'(cmd_ready), 32'd0);
    end
    chk("mid_rd_cnt", ra_q.size(), nr);
    chk("mid_wr_cnt", wa_q.size(), nw);
    @(posedge clk); #1;
    clr_logs();
    rst_n = 1'b1;
    wait_clear("resume");

`ifdef RAM8_INIT_CLEAR_EN
    ex[0] = 8'h00;
`else
    ex[0] = 8'hA1;
`endif
    @(posedge clk); #1;
    do_read(3'd2, 3'd0, 0, "post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram8_initiator.md
RAM8_INITIATOR -- requirements
Module: ram8_initiator

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 cmd_valid  input  1  command request.
REQ-004 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-005 cmd_wr  input  1  1 = write burst; 0 = read burst.
REQ-006 cmd_addr  input  3  burst start address.
REQ-007 cmd_len  input  3  beats minus one (0 = 1 beat, 7 = 8 beats).
REQ-008 wvalid / wready / wdata  input / output / input  1 / 1 / 8  write-data stream.
REQ-009 rvalid / rready / rdata / rlast  output / input / output / output  1 / 1 / 8 / 1  read-data stream; rlast marks the final beat.
REQ-010 ram_wr_enb, ram_wr_addr[2:0], ram_din[7:0]  output  RAM write port.
REQ-011 ram_rd_enb, ram_rd_addr[2:0]  output  RAM read port.
REQ-012 ram_dataout  input  8  RAM read data, registered in the RAM; valid the cycle after the ram_rd_enb edge.

Function
REQ-013 FSM states: CLEAR (macro only), IDLE, WRITE, RD_ISSUE, RD_CAP, RD_RESP.
REQ-014 IDLE: cmd_ready=1, all other handshake outputs 0; on acceptance, latch the address and beat count, then go to WRITE (cmd_wr=1) or RD_ISSUE.
REQ-015 WRITE: wready=1; ram_wr_enb=wvalid, ram_wr_addr=current address and ram_din=wdata, all combinational in the same cycle.
REQ-016 WRITE exit: each accepted beat increments the address; after beat cmd_len+1 the FSM returns to IDLE.
REQ-017 WRITE stall: wvalid=0 stalls the burst with ram_wr_enb=0 and no state change.
REQ-018 RD_ISSUE: ram_rd_enb=1 for exactly one cycle at the current address, then RD_CAP.
REQ-019 RD_CAP: capture ram_dataout into the rdata register, then RD_RESP.
REQ-020 RD_RESP: rvalid=1, with rdata and rlast stable until rready.
REQ-021 RD_RESP exit: on rvalid && rready, go to IDLE if this was the last beat, else increment the address and go to RD_ISSUE.
REQ-022 Read latency: first rvalid three cycles after the command-accept edge; with rready held high, one beat every three cycles.
REQ-023 The address wraps modulo 8 within a burst (e.g. start 6, len 3 -> 6,7,0,1).
REQ-024 ram_wr_enb and ram_rd_enb are never high in the same cycle.
REQ-025 Bursts never overlap; cmd_ready=0 in every state except IDLE.
REQ-026 rready=0 stalls indefinitely with no further RAM strobes.

Reset
REQ-027 On rst_n low, all outputs are 0, state = IDLE (CLEAR with the macro), and counters are 0.
REQ-028 Reset mid-burst aborts the burst immediately; no RAM strobe is issued while rst_n is low.
REQ-029 Operation resumes on the first rising edge after rst_n rises.

Configuration
REQ-030 Macro RAM8_INIT_CLEAR_EN defined: after reset the FSM is in CLEAR.
REQ-031 CLEAR writes 0x00 to addresses 0..7 on 8 consecutive cycles (ram_wr_enb=1), holding cmd_ready=0, then goes to IDLE.
REQ-032 Macro undefined: no CLEAR state; IDLE directly after reset.

Structure
REQ-033 Package ram8_pkg holds ADDR_W=3, DATA_W=8, DEPTH=8 and the FSM state enum typedef.
REQ-034 One sub-module, ram8_burst_ctr: loads start address and length, increments the address modulo DEPTH and flags the last beat; shared by the write, read and CLEAR paths.

Verification
REQ-035 Write burst: addr=2, len=3, wdata 0xA1..0xA4 -> ram_wr_enb on 4 cycles at addresses 2,3,4,5, then IDLE.
REQ-036 Read-back: read addr=2, len=3 with rready=1 against a RAM model -> rdata 0xA1..0xA4, rlast on 0xA4 only, first rvalid 3 cycles after accept.
REQ-037 Wrap: write addr=6, len=3 -> addresses 6,7,0,1.
REQ-038 Backpressure: rready low for 10 cycles -> rvalid and rdata stable, ram_rd_enb=0 throughout.
REQ-039 Write stall: wvalid low for 5 cycles -> ram_wr_enb=0 throughout.
REQ-040 Reset mid-burst: rst_n low during a read burst -> outputs 0 at once, IDLE (or CLEAR) after release; with RAM8_INIT_CLEAR_EN, 8 zero writes precede cmd_ready=1.
